// File: rtl/mos6502_bus_responder.sv
// rtl/mos6502_bus_responder.sv - 6502-style multiplexed bus responder with RAM, I/O port and reset vector
//
// Purpose: decodes a three-phase multiplexed bus cycle and serves reads and writes to
//          a small RAM, an output port, an input port and the reset vector.
//          I/O-page cycles (0x80xx) get WAIT_IO wait states.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus_in       phase 0 ADDR[7:0], phase 1 ADDR[15:8], phase 2 write data
//   frame        high only in phase 0
//   rw, sync     sampled in phase 1 (1 = read, 1 = opcode fetch)
//   bus_out      read data, valid while bus_oe is high
//   bus_oe       read data valid (DATA clock of read cycles only)
//   rdy          low while the CPU side must hold phase 2
//   port_out     output port register (0x8000)
//   port_in      input port (0x8001)
//   fetch_count  saturating count of completed opcode-fetch reads
//   bus_err      high for the clock in which frame interrupts a cycle
module mos6502_bus_responder #(
   parameter int          RAM_WORDS    = 64,
   parameter int          WAIT_IO      = 2,
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  bus_in,
   input  logic        frame,
   input  logic        rw,
   input  logic        sync,
   output logic [7:0]  bus_out,
   output logic        bus_oe,
   output logic        rdy,
   output logic [7:0]  port_out,
   input  logic [7:0]  port_in,
   output logic [15:0] fetch_count,
   output logic        bus_err
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR_HI,
      S_WAIT,
      S_DATA
   } state_t;

   state_t      state, state_next;
   logic [7:0]  addr_lo, addr_hi;
   logic        rw_q, sync_q;
   logic [2:0]  wait_cnt;
   logic [7:0]  ram [RAM_WORDS];

   logic        latch_lo, latch_hi, load_rd, wait_load, wait_dec, commit;
   logic [15:0] cur_addr;
   logic        cur_rw;
   logic [7:0]  rd_data;
   logic        io_page;

   function automatic logic ram_hit(input logic [15:0] a);
      return (a[15:8] == 8'h00) && ({1'b0, a[7:0]} < 9'(RAM_WORDS));
   endfunction

   // In ADDR_HI the high address byte and rw are still on the inputs; the read
   // data must be captured on the same edge that enters DATA, so use them directly.
   assign cur_addr = (state == S_ADDR_HI) ? {bus_in, addr_lo} : {addr_hi, addr_lo};
   assign cur_rw   = (state == S_ADDR_HI) ? rw : rw_q;
   assign io_page  = (bus_in == 8'h80) && (WAIT_IO > 0);

   assign rdy     = (state != S_WAIT);
   assign bus_err = frame && (state != S_IDLE);

   always_comb begin
      state_next = state;
      latch_lo   = 1'b0;
      latch_hi   = 1'b0;
      load_rd    = 1'b0;
      wait_load  = 1'b0;
      wait_dec   = 1'b0;
      commit     = 1'b0;
      if (frame) begin
         // A frame in any state starts a new cycle; an interrupted cycle is dropped.
         latch_lo   = 1'b1;
         state_next = S_ADDR_HI;
      end else begin
         case (state)
            S_IDLE: ;
            S_ADDR_HI: begin
               latch_hi = 1'b1;
               if (io_page) begin
                  wait_load  = 1'b1;
                  state_next = S_WAIT;
               end else begin
                  load_rd    = 1'b1;
                  state_next = S_DATA;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 3'd1) begin
                  load_rd    = 1'b1;
                  state_next = S_DATA;
               end else begin
                  wait_dec = 1'b1;
               end
            end
            S_DATA: begin
               commit     = 1'b1;
               state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = 8'hFF;
      if (ram_hit(cur_addr))
         rd_data = ram[cur_addr[AW-1:0]];
      else if (cur_addr == 16'h8000)
         rd_data = port_out;
      else if (cur_addr == 16'h8001)
         rd_data = port_in;
      else if (cur_addr == 16'hFFFC)
         rd_data = RESET_VECTOR[7:0];
      else if (cur_addr == 16'hFFFD)
         rd_data = RESET_VECTOR[15:8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         addr_lo     <= 8'h00;
         addr_hi     <= 8'h00;
         rw_q        <= 1'b1;
         sync_q      <= 1'b0;
         wait_cnt    <= 3'd0;
         bus_out     <= 8'h00;
         bus_oe      <= 1'b0;
         port_out    <= 8'h00;
         fetch_count <= 16'h0000;
      end else begin
         state <= state_next;
         if (latch_lo)
            addr_lo <= bus_in;
         if (latch_hi) begin
            addr_hi <= bus_in;
            rw_q    <= rw;
            sync_q  <= sync;
         end
         if (wait_load)
            wait_cnt <= 3'(WAIT_IO);
         else if (wait_dec)
            wait_cnt <= wait_cnt - 3'd1;
         else
            wait_cnt <= 3'd0;
         bus_oe <= load_rd && cur_rw;
         if (load_rd && cur_rw)
            bus_out <= rd_data;
         if (commit) begin
            if (!rw_q && ({addr_hi, addr_lo} == 16'h8000))
               port_out <= bus_in;
            if (rw_q && sync_q && (fetch_count != 16'hFFFF))
               fetch_count <= fetch_count + 16'd1;
         end
      end
   end

   // RAM is not reset; reset drops state to IDLE so no commit can follow it.
   always_ff @(posedge clk) begin
      if (commit && !rw_q && ram_hit({addr_hi, addr_lo}))
         ram[addr_lo[AW-1:0]] <= bus_in;
   end

endmodule

// File: tb/tb_mos6502_bus_responder.sv
// tb/tb_mos6502_bus_responder.sv - scoreboard bench for mos6502_bus_responder
module tb_mos6502_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  bus_in;
   logic        frame, rw, sync;
   logic [7:0]  bus_out;
   logic        bus_oe, rdy;
   logic [7:0]  port_out;
   logic [7:0]  port_in;
   logic [15:0] fetch_count;
   logic        bus_err;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   mos6502_bus_responder #(
      .RAM_WORDS(64),
      .WAIT_IO(2),
      .RESET_VECTOR(16'h0200)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus_in(bus_in),
      .frame(frame),
      .rw(rw),
      .sync(sync),
      .bus_out(bus_out),
      .bus_oe(bus_oe),
      .rdy(rdy),
      .port_out(port_out),
      .port_in(port_in),
      .fetch_count(fetch_count),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every clock that presents read data consumes one expected byte.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus_oe === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read: got %h expected no read data", bus_out);
         end else begin
            check("read_data", {8'h00, bus_out}, {8'h00, exp_q.pop_front()});
         end
      end
   end

   task automatic bus_cycle(input logic [15:0] addr, input bit rd, input bit sy,
                            input logic [7:0] wd, input logic [7:0] exp, output int waits);
      @(negedge clk);
      frame  = 1'b1;
      bus_in = addr[7:0];
      @(negedge clk);
      frame  = 1'b0;
      bus_in = addr[15:8];
      rw     = rd;
      sync   = sy;
      if (rd)
         exp_q.push_back(exp);
      @(negedge clk);
      bus_in = rd ? 8'h00 : wd;
      waits  = 0;
      while (rdy !== 1'b1 && waits < 20) begin
         check("bus_oe_in_wait", {15'd0, bus_oe}, 16'd0);
         waits++;
         @(negedge clk);
      end
      if (waits >= 20) begin
         total++;
         bad++;
         $display("FAIL rdy_timeout: got rdy=%b expected 1 within 20 clocks", rdy);
      end
      check("bus_oe_data", {15'd0, bus_oe}, {15'd0, rd});
   endtask

   task automatic rd_cyc(input logic [15:0] addr, input bit sy, input logic [7:0] exp);
      int w;
      bus_cycle(addr, 1'b1, sy, 8'h00, exp, w);
   endtask

   task automatic wr_cyc(input logic [15:0] addr, input bit sy, input logic [7:0] wd);
      int w;
      bus_cycle(addr, 1'b0, sy, wd, 8'h00, w);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n   = 1'b0;
      frame   = 1'b0;
      bus_in  = 8'h00;
      rw      = 1'b1;
      sync    = 1'b0;
      port_in = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_bus_out", {8'h00, bus_out}, 16'h0000);
      check("rst_bus_oe", {15'd0, bus_oe}, 16'd0);
      check("rst_rdy", {15'd0, rdy}, 16'd1);
      check("rst_port_out", {8'h00, port_out}, 16'h0000);
      check("rst_fetch_count", fetch_count, 16'h0000);
      check("rst_bus_err", {15'd0, bus_err}, 16'd0);
      rst_n = 1'b1;

      // Reset vector bytes
      rd_cyc(16'hFFFC, 1'b0, 8'h00);
      rd_cyc(16'hFFFD, 1'b0, 8'h02);

      // RAM, RAM boundary and unmapped addresses
      wr_cyc(16'h0010, 1'b0, 8'h5A);
      rd_cyc(16'h0010, 1'b0, 8'h5A);
      wr_cyc(16'h003F, 1'b0, 8'h3C);
      rd_cyc(16'h003F, 1'b0, 8'h3C);
      rd_cyc(16'h0040, 1'b0, 8'hFF);
      rd_cyc(16'h0110, 1'b0, 8'hFF);
      rd_cyc(16'h8002, 1'b0, 8'hFF);

      // I/O writes and reads with wait states
      bus_cycle(16'h8000, 1'b0, 1'b0, 8'hC3, 8'h00, w);
      check("io_write_waits", 16'(w), 16'd2);
      @(negedge clk);
      check("port_out_c3", {8'h00, port_out}, 16'h00C3);
      port_in = 8'h7E;
      bus_cycle(16'h8001, 1'b1, 1'b0, 8'h00, 8'h7E, w);
      check("io_read_waits", 16'(w), 16'd2);
      rd_cyc(16'h8000, 1'b0, 8'hC3);
      wr_cyc(16'h8000, 1'b0, 8'h3D);
      rd_cyc(16'h8000, 1'b0, 8'h3D);

      // Opcode fetch counting: only reads with sync=1 count
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      rd_cyc(16'h0010, 1'b0, 8'h5A);
      wr_cyc(16'h0011, 1'b1, 8'h77);
      @(negedge clk);
      check("fetch_count_3", fetch_count, 16'd3);

      // Framing error during phase 2 of a write to 0x0020
      wr_cyc(16'h0020, 1'b0, 8'h11);
      @(negedge clk);
      frame  = 1'b1;
      bus_in = 8'h20;
      @(negedge clk);
      frame  = 1'b0;
      bus_in = 8'h00;
      rw     = 1'b0;
      @(negedge clk);
      bus_in = 8'h99;
      frame  = 1'b1;
      #1;
      check("bus_err_pulse", {15'd0, bus_err}, 16'd1);
      bus_in = 8'h20;
      @(negedge clk);
      frame  = 1'b0;
      bus_in = 8'h00;
      rw     = 1'b1;
      exp_q.push_back(8'h11);
      #1;
      check("bus_err_cleared", {15'd0, bus_err}, 16'd0);
      @(negedge clk);
      check("abort_recovery_oe", {15'd0, bus_oe}, 16'd1);
      check("abort_no_fetch", fetch_count, 16'd3);

      // Reset during the wait states of an I/O write
      @(negedge clk);
      frame  = 1'b1;
      bus_in = 8'h00;
      @(negedge clk);
      frame  = 1'b0;
      bus_in = 8'h80;
      rw     = 1'b0;
      @(negedge clk);
      bus_in = 8'h55;
      #1;
      check("wait_rdy_low", {15'd0, rdy}, 16'd0);
      rst_n = 1'b0;
      #1;
      check("async_rst_rdy", {15'd0, rdy}, 16'd1);
      check("async_rst_port_out", {8'h00, port_out}, 16'h0000);
      check("async_rst_fetch", fetch_count, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("no_commit_after_rst", {8'h00, port_out}, 16'h0000);
      rd_cyc(16'h8000, 1'b0, 8'h00);

      // Saturation: preload the counter near the top, then count real fetches
      force dut.fetch_count = 16'hFFFB;
      @(negedge clk);
      release dut.fetch_count;
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      @(negedge clk);
      check("fetch_reach_ffff", fetch_count, 16'hFFFF);
      rd_cyc(16'h0010, 1'b1, 8'h5A);
      @(negedge clk);
      check("fetch_saturate", fetch_count, 16'hFFFF);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mos6502_bus_responder.md
MOS6502_BUS_RESPONDER -- requirements
Module: mos6502_bus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 64, RAM depth in bytes, mapped at 0x0000..RAM_WORDS-1, power of two, max 256.
REQ-002 Parameter WAIT_IO, default 2, wait-state clocks inserted for I/O-region cycles, range 0..7.
REQ-003 Parameter RESET_VECTOR, default 16'h0000, value returned at 0xFFFC (low byte) and 0xFFFD (high byte).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 bus_in  input  8  multiplexed bus from CPU side: ADDR[7:0] in phase 0, ADDR[15:8] in phase 1, write data in phase 2.
REQ-007 frame  input  1  high only during phase 0 of a bus cycle.
REQ-008 rw  input  1  sampled in phase 1: 1 = read, 0 = write.
REQ-009 sync  input  1  sampled in phase 1: 1 = opcode fetch.
REQ-010 bus_out  output  8  read data returned to CPU side.
REQ-011 bus_oe  output  1  high while bus_out carries valid read data.
REQ-012 rdy  output  1  0 = CPU side must hold phase 2 (wait state).
REQ-013 port_out  output  8  output port register.
REQ-014 port_in  input  8  input port, sampled on read.
REQ-015 fetch_count  output  16  count of completed opcode-fetch reads.
REQ-016 bus_err  output  1  one-clock pulse on framing error.

Function
REQ-017 FSM states: IDLE, ADDR_HI, WAIT, DATA; one clk per phase.
REQ-018 IDLE: frame=1 -> latch bus_in as addr_lo, go ADDR_HI; frame=0 -> stay.
REQ-019 ADDR_HI: latch bus_in as addr_hi, rw, sync; go WAIT if address in 0x8000..0x80FF and WAIT_IO>0, else DATA.
REQ-020 WAIT: rdy=0, bus_oe=0; down-counter from WAIT_IO; go DATA on the clock it reaches 1.
REQ-021 DATA: rdy=1; one clk; go IDLE.
REQ-022 Read data registered on entry to DATA; bus_out/bus_oe valid for the whole DATA clock; bus_oe=0 in all other states and on writes.
REQ-023 Read map: RAM hit -> RAM byte; 0x8000 -> port_out; 0x8001 -> port_in sampled at DATA entry; 0xFFFC/0xFFFD -> RESET_VECTOR bytes; all other addresses -> 0xFF.
REQ-024 Write commit at the rising edge ending DATA using bus_in: RAM hit -> RAM byte; 0x8000 -> port_out; all other addresses ignored.
REQ-025 RAM hit = addr_hi==0 and addr_lo<RAM_WORDS; no aliasing above.
REQ-026 fetch_count += 1 at end of DATA when rw=1 and sync=1; saturates at 0xFFFF.
REQ-027 frame=1 in ADDR_HI, WAIT or DATA: abort cycle with no commit, no fetch count, bus_err=1 for that clk; the clk is treated as phase 0 (addr_lo latched, go ADDR_HI).
REQ-028 Write to 0x8000 and read of 0x8000 in the next cycle returns the new value (no hazard).
REQ-029 rdy=1 in every state except WAIT.

Reset
REQ-030 rst_n=0 -> state IDLE, bus_out=0x00, bus_oe=0, rdy=1, port_out=0x00, fetch_count=0, bus_err=0, wait counter 0; immediate, clock-independent.
REQ-031 RAM contents not reset; reads before first write undefined.
REQ-032 Reset asserted mid-cycle discards the cycle; no commit.
REQ-033 First bus cycle accepted on the first frame=1 clock after rst_n deasserts.

Verification
REQ-034 Read 0xFFFC then 0xFFFD with RESET_VECTOR=16'h0200 -> bus_out 0x00 then 0x02, bus_oe=1 only in the DATA clock.
REQ-035 Write 0x5A to 0x0010, read 0x0010 -> 0x5A; read 0x0040 (RAM_WORDS=64) -> 0xFF.
REQ-036 Write 0xC3 to 0x8000 with WAIT_IO=2 -> rdy=0 for exactly 2 clks, port_out=0xC3 after DATA; read 0x8001 with port_in=0x7E -> 0x7E.
REQ-037 Three reads with sync=1 and one read with sync=0 -> fetch_count=3; 65540 sync reads -> fetch_count=0xFFFF.
REQ-038 frame=1 during phase 2 of a write to 0x0020 -> bus_err pulse 1 clk, RAM[0x20] unchanged, new cycle completes correctly.
REQ-039 rst_n low during WAIT of an 0x8000 write -> rdy=1, port_out=0x00 immediately; no commit after release.
